// File: rtl/ram_pixel_serializer.sv
// ram_pixel_serializer: reads NUM_ROWS row words from a result RAM with
// one cycle of read latency. Each row is then streamed out one binary pixel
// per accepted transfer, LSB (column 0) first. Downstream can stall the stream
// with pixel_ready. Frame, row and end-of-frame markers travel with each pixel.
module ram_pixel_serializer #(
  parameter int NUM_ROWS  = 48,
  parameter int ROW_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROW_WIDTH-1:0] ramdata,
  output logic [6:0]           ramaddress,
  output logic                 read_request,
  output logic                 pixel,
  output logic                 pixel_valid,
  input  logic                 pixel_ready,
  output logic                 sof,
  output logic                 eol,
  output logic                 eof,
  output logic                 busy,
  output logic                 done
);

  localparam int                 COL_W    = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
  localparam logic [COL_W-1:0]   COL_LAST = COL_W'(ROW_WIDTH - 1);
  localparam logic [6:0]         ROW_LAST = 7'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [6:0]           row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_WIDTH-1:0] shreg_q, shreg_d;
  logic                 transfer;

  // A pixel moves only while it is on offer and downstream accepts it.
  assign transfer = (state_q == ST_SHIFT) && pixel_ready;

  // The row counter register drives the RAM address directly, so the address
  // is glitch-free and always reflects the current row.
  assign ramaddress = row_q;

  // State, counters and the row shift register; reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      // NOTE: the row buffer is cleared on reset as well.
      // Nothing reads it outside SHIFT, but this keeps an aborted frame from
      // leaving stale pixel data behind.
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic: request a row, capture it, shift it out, repeat per row.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
          row_d   = '0;
        end
      end
      ST_REQ: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // RAM data for the address issued in REQ is valid this cycle.
        shreg_d = ramdata;
        col_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (transfer) begin
          if (col_q == COL_LAST) begin
            if (row_q == ROW_LAST) begin
              state_d = ST_DONE;
            end else begin
              row_d   = row_q + 7'd1;
              state_d = ST_REQ;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // start is deliberately ignored here; a new frame needs IDLE first.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state; every strobe is 0 unless its state owns it.
  always_comb begin
    read_request = 1'b0;
    pixel        = 1'b0;
    pixel_valid  = 1'b0;
    sof          = 1'b0;
    eol          = 1'b0;
    eof          = 1'b0;
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    case (state_q)
      ST_REQ: begin
        read_request = 1'b1;
      end
      ST_SHIFT: begin
        // col and shreg only move on a transfer, so a stall holds all of these.
        pixel_valid = 1'b1;
        pixel       = shreg_q[col_q];
        sof         = (row_q == 7'd0) && (col_q == '0);
        eol         = (col_q == COL_LAST);
        eof         = (col_q == COL_LAST) && (row_q == ROW_LAST);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ram_pixel_serializer.sv
// Bench for ram_pixel_serializer. A RAM model with one cycle of read latency
// feeds the design. Starting a frame pushes its expected pixel beats into a
// queue. A negedge monitor pops and compares each accepted pixel, and it
// also records frame timing, address order and stall behaviour.
module tb_ram_pixel_serializer;

  localparam int NUM_ROWS     = 48;
  localparam int ROW_WIDTH    = 64;
  localparam int FRAME_XFERS  = NUM_ROWS * ROW_WIDTH;
  localparam int FRAME_CYCLES = NUM_ROWS * (ROW_WIDTH + 2);

  typedef struct packed {
    logic pixel;
    logic sof;
    logic eol;
    logic eof;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [ROW_WIDTH-1:0] ramdata;
  logic [6:0]           ramaddress;
  logic                 read_request;
  logic                 pixel;
  logic                 pixel_valid;
  logic                 pixel_ready;
  logic                 sof;
  logic                 eol;
  logic                 eof;
  logic                 busy;
  logic                 done;

  logic [ROW_WIDTH-1:0] ram [128];
  logic [ROW_WIDTH-1:0] pat [4] = '{64'h8000_0000_0000_0001,
                                    64'hDEAD_BEEF_0123_4567,
                                    64'hFFFF_0000_AAAA_5555,
                                    64'h0F0F_F0F0_3C3C_C3C3};

  beat_t exp_q[$];
  int    req_addr_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int frame_xfers, eol_count, eof_cyc, done_count, done_cyc, first_req_cyc, stall_cycles;
  logic [ROW_WIDTH-1:0] row0_bits;
  logic  stalled = 1'b0;
  beat_t held;

  ram_pixel_serializer #(
    .NUM_ROWS  (NUM_ROWS),
    .ROW_WIDTH (ROW_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ramdata      (ramdata),
    .ramaddress   (ramaddress),
    .read_request (read_request),
    .pixel        (pixel),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .sof          (sof),
    .eol          (eol),
    .eof          (eof),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Result RAM: data for the strobed address appears one cycle later.
  always @(posedge clk) if (read_request) ramdata <= ram[ramaddress];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every accepted pixel against the scoreboard.
  always @(negedge clk) begin
    beat_t act;
    beat_t e;
    act = {pixel, sof, eol, eof};
    if (!rst) begin
      if (read_request) begin
        req_addr_q.push_back(int'(ramaddress));
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (!pixel_valid) check("flags_outside_shift", {sof, eol, eof}, 3'b000);
      if (pixel_valid && pixel_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pixel_beat", act, e);
        end
        if (frame_xfers < ROW_WIDTH) row0_bits[frame_xfers[5:0]] = pixel;
        if (eol) eol_count++;
        if (eof) eof_cyc = cyc;
        frame_xfers++;
        stalled = 1'b0;
      end else if (pixel_valid) begin
        if (stalled) check("stall_hold", act, held);
        held = act;
        stalled = 1'b1;
        stall_cycles++;
      end else begin
        stalled = 1'b0;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    frame_xfers   = 0;
    eol_count     = 0;
    eof_cyc       = -1;
    done_count    = 0;
    done_cyc      = -1;
    first_req_cyc = -1;
    stall_cycles  = 0;
    row0_bits     = '0;
    req_addr_q.delete();
  endtask

  task automatic push_frame();
    beat_t b;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < ROW_WIDTH; c++) begin
        b.pixel = ram[r][c];
        b.sof   = (r == 0) && (c == 0);
        b.eol   = (c == ROW_WIDTH - 1);
        b.eof   = (r == NUM_ROWS - 1) && (c == ROW_WIDTH - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic start_frame();
    clear_stats();
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait until the given transfer index is on offer (bounded).
  task automatic wait_xfers(input string name, input int target);
    for (int i = 0; i < FRAME_CYCLES + 200 && !(frame_xfers == target && pixel_valid); i++) tick();
    check(name, frame_xfers, target);
  endtask

  // Wait for the done pulse (bounded); optionally poke start while in DONE.
  task automatic wait_done(input string name, input bit start_in_done);
    for (int i = 0; i < FRAME_CYCLES + 200 && !done; i++) tick();
    check(name, done, 1);
    if (start_in_done) start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_addr_order(input string name);
    check({name, "_req_count"}, req_addr_q.size(), NUM_ROWS);
    for (int i = 0; i < req_addr_q.size() && i < NUM_ROWS; i++) check({name, "_req_addr"}, req_addr_q[i], i);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b1;
    pixel_ready = 1'b1;
    ramdata     = '0;
    for (int r = 0; r < 128; r++) ram[r] = pat[r % 4];
    clear_stats();

    // Reset with start held high: everything must stay at 0.
    tick();
    tick();
    check("reset_outputs", {ramaddress, read_request, pixel, pixel_valid, sof, eol, eof, busy, done}, 0);
    check("reset_busy", busy, 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("idle_after_reset", {busy, read_request, pixel_valid}, 0);

    // Frame 1: full frame with ready held high, bit order on row 0.
    start_frame();
    wait_done("f1_done", 1'b0);
    check("f1_xfers", frame_xfers, FRAME_XFERS);
    check("f1_eol_count", eol_count, NUM_ROWS);
    check("f1_done_after_eof", done_cyc - eof_cyc, 1);
    check("f1_req_to_done", done_cyc - first_req_cyc, FRAME_CYCLES);
    check("f1_done_count", done_count, 1);
    check("f1_row0_bits", row0_bits, 64'h8000_0000_0000_0001);
    check("f1_queue_empty", exp_q.size(), 0);
    check_addr_order("f1");

    // Frame 2: 5-cycle stall at row 3 col 10, start pulses at row 5 and in DONE.
    start_frame();
    wait_xfers("f2_reach_r3c10", 3 * ROW_WIDTH + 10);
    pixel_ready = 1'b0;
    repeat (5) tick();
    pixel_ready = 1'b1;
    check("f2_stall_cycles", stall_cycles, 5);
    wait_xfers("f2_reach_r5c0", 5 * ROW_WIDTH);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("f2_done", 1'b1);
    check("f2_xfers", frame_xfers, FRAME_XFERS);
    check("f2_eol_count", eol_count, NUM_ROWS);
    check("f2_req_to_done", done_cyc - first_req_cyc, FRAME_CYCLES + 5);
    check("f2_queue_empty", exp_q.size(), 0);
    check_addr_order("f2");
    repeat (3) tick();
    check("f2_idle_after_done", {busy, read_request}, 0);
    check("f2_single_done", done_count, 1);

    // Frame 3: reset at row 20 col 30, no done may follow.
    start_frame();
    wait_xfers("f3_reach_r20c30", 20 * ROW_WIDTH + 30);
    rst = 1'b1;
    tick();
    check("abort_outputs", {ramaddress, read_request, pixel, pixel_valid, sof, eol, eof, busy, done}, 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (4) tick();
    check("abort_no_done", done_count, 0);
    check("abort_idle", busy, 0);

    // Frame 4: restart after abort reads address 0 first, sof on first beat.
    start_frame();
    wait_done("f4_done", 1'b0);
    check("f4_first_addr", (req_addr_q.size() > 0) ? req_addr_q[0] : -1, 0);
    check("f4_xfers", frame_xfers, FRAME_XFERS);
    check("f4_done_count", done_count, 1);
    check("f4_row0_bits", row0_bits, 64'h8000_0000_0000_0001);
    check("f4_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_pixel_serializer.md
RAM_PIXEL_SERIALIZER -- requirements
Module: ram_pixel_serializer

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 48, meaning the number of image rows read per frame (1..128).
REQ-002 SHALL have parameter ROW_WIDTH, default 64, meaning the pixels per row, which equals the RAM word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a frame start request sampled in IDLE.
REQ-006 SHALL have port ramdata, input, ROW_WIDTH, the filtered row word returned by the result RAM.
REQ-007 SHALL have port ramaddress, output, 7, the RAM row address.
REQ-008 SHALL have port read_request, output, 1, the RAM read strobe.
REQ-009 SHALL have port pixel, output, 1, the current binary pixel.
REQ-010 SHALL have port pixel_valid, output, 1, which indicates that pixel is valid.
REQ-011 SHALL have port pixel_ready, input, 1, the downstream accept signal.
REQ-012 SHALL have port sof, output, 1, high with the first pixel of a frame (row 0, col 0).
REQ-013 SHALL have port eol, output, 1, high with the last pixel of each row (col ROW_WIDTH-1).
REQ-014 SHALL have port eof, output, 1, high with the last pixel of a frame.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 SHALL have port done, output, 1, a one-cycle pulse after the frame completes.

Function
REQ-017 SHALL implement the FSM states IDLE, REQ, LOAD, SHIFT and DONE.
REQ-018 SHALL move from IDLE to REQ on start=1, with row=0; otherwise it SHALL stay in IDLE.
REQ-019 SHALL, in REQ, assert read_request=1 with ramaddress=row for exactly one cycle, then go to LOAD.
REQ-020 SHALL treat RAM read latency as 1 cycle: in LOAD, ramdata is captured into the row shift register, col=0, then the FSM goes to SHIFT.
REQ-021 SHALL, in SHIFT, drive pixel_valid=1 and pixel=shreg[col]; bit 0 is column 0, sent first (LSB first).
REQ-022 SHALL count a transfer only on a cycle with pixel_valid=1 and pixel_ready=1; each transfer increments col.
REQ-023 SHALL hold pixel, sof, eol and eof stable while pixel_valid=1 and pixel_ready=0.
REQ-024 SHALL, on a transfer at col=ROW_WIDTH-1 with row<NUM_ROWS-1, increment row and go to REQ.
REQ-025 SHALL, on a transfer at col=ROW_WIDTH-1 with row=NUM_ROWS-1, go to DONE.
REQ-026 SHALL assert done=1 for one cycle in DONE, then return to IDLE; the next start is accepted no earlier than the cycle after DONE.
REQ-027 SHALL ignore start whenever state is not IDLE, including in DONE.
REQ-028 SHALL keep pixel_valid, sof, eol and eof at 0 outside SHIFT.
REQ-029 SHALL keep read_request at 0 outside REQ.
REQ-030 SHALL hold ramaddress at the current row at all times (registered, 7 bits); ROW_WIDTH and row counter widths SHALL not overflow for NUM_ROWS≤128.
REQ-031 SHALL, with pixel_ready held at 1, take exactly NUM_ROWS*(ROW_WIDTH+2) cycles from the first REQ cycle to the DONE cycle.

Reset
REQ-032 SHALL make rst=1 force state=IDLE, row=0, col=0, shreg=0 on the next edge, from any state including mid-frame.
REQ-033 SHALL reset every output to 0 (ramaddress, read_request, pixel, pixel_valid, sof, eol, eof, busy, done).
REQ-034 SHALL give rst priority over start when both are asserted in the same cycle.
REQ-035 SHALL not produce a done pulse for a frame aborted by reset.

Verification
REQ-036 SHALL cover reset: rst=1 for 2 cycles with start=1 -> all outputs 0, busy=0, state IDLE.
REQ-037 SHALL cover bit order: RAM row0=64'h8000_0000_0000_0001, ready=1 -> pixel=1 at col0 (sof=1) and at col63 (eol=1), 0 elsewhere in the row.
REQ-038 SHALL cover a full frame: NUM_ROWS=48, ready=1 -> 3072 transfers, 48 eol pulses, eof on transfer 3072, done 1 cycle after it, 3168 cycles REQ-to-DONE, read_request addresses 0..47 in order.
REQ-039 SHALL cover backpressure: pixel_ready=0 for 5 cycles at row 3 col 10 -> pixel_valid=1 and pixel/eol stable for all 5 cycles, col 10 transferred once, no pixel lost or duplicated.
REQ-040 SHALL cover start while busy: pulse start at row 5 and again in DONE -> no restart, row counter continues, single done pulse.
REQ-041 SHALL cover reset mid-frame: rst at row 20 col 30 -> outputs 0 next cycle, no done; a following start reads address 0 first with sof on the first transfer.
